verify_frame_checker: RTL



---
 rtl/verify_frame_checker_if.sv | 25 ++
 rtl/verify_frame_checker.sv | 127 ++++++++++++
 2 files changed

// File: rtl/verify_frame_checker_if.sv
// Result-beat stream from the per-byte verify stage into the frame checker.
// One beat carries the three per-byte check flags.
interface verify_frame_checker_if;
    logic in_valid;
    logic in_ready;
    logic valid_flag;
    logic hash_match;
    logic enc_match;

    modport master (
        output in_valid,
        output valid_flag,
        output hash_match,
        output enc_match,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  valid_flag,
        input  hash_match,
        input  enc_match,
        output in_ready
    );
endinterface

// File: rtl/verify_frame_checker.sv
// Frame-level verdict over per-byte verify results: saturating error
// counters, first failing byte index and an end-of-frame pass/fail pulse.
module verify_frame_checker #(
    parameter  int FRAME_LEN = 16,
    parameter  int CNT_W     = 8,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    verify_frame_checker_if.slave   beat,
    output logic                    busy,
    output logic                    done,
    output logic                    frame_pass,
    output logic [CNT_W-1:0]        dec_err_cnt,
    output logic [CNT_W-1:0]        hash_err_cnt,
    output logic [CNT_W-1:0]        enc_err_cnt,
    output logic                    first_err_vld,
    output logic [IDX_W-1:0]        first_err_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  dec_d;
    logic [CNT_W-1:0]  hash_d;
    logic [CNT_W-1:0]  enc_d;
    logic              fire;
    logic              last;
    logic              any_err;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c,
        input logic             e
    );
        return (e && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
    endfunction

    assign fire    = beat.in_valid & beat.in_ready;
    assign last    = (idx_q == IDX_LAST);
    assign any_err = ~(beat.valid_flag & beat.hash_match & beat.enc_match);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (fire && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat.in_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            IDLE: ;
            RUN: begin
                beat.in_ready = 1'b1;
                busy          = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        dec_d  = sat_inc(dec_err_cnt,  ~beat.valid_flag);
        hash_d = sat_inc(hash_err_cnt, ~beat.hash_match);
        enc_d  = sat_inc(enc_err_cnt,  ~beat.enc_match);
    end

    // Verdict is latched with the last beat so it is visible alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            dec_err_cnt   <= '0;
            hash_err_cnt  <= '0;
            enc_err_cnt   <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            frame_pass    <= 1'b0;
        end else if (state_q == IDLE && start) begin
            idx_q         <= '0;
            dec_err_cnt   <= '0;
            hash_err_cnt  <= '0;
            enc_err_cnt   <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            frame_pass    <= 1'b0;
        end else if (fire) begin
            idx_q        <= idx_q + IDX_W'(1);
            dec_err_cnt  <= dec_d;
            hash_err_cnt <= hash_d;
            enc_err_cnt  <= enc_d;
            if (any_err && !first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_idx <= idx_q;
            end
            if (last) begin
                frame_pass <= (dec_d == '0) && (hash_d == '0) && (enc_d == '0);
            end
        end
    end

endmodule
